// File: rtl/regfile_wb.sv
// Register file with two combinational read ports, one write port, optional
// write-through bypass and a per-register busy scoreboard for pending writes.
module regfile_wb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     RegWrite,
  input  logic [ADDR_W-1:0]        WriteRegister,
  input  logic [DATA_W-1:0]        WriteData,
  input  logic [ADDR_W-1:0]        ReadReg1,
  input  logic [ADDR_W-1:0]        ReadReg2,
  output logic [DATA_W-1:0]        ReadData1,
  output logic [DATA_W-1:0]        ReadData2,
  input  logic                     IssueValid,
  input  logic [ADDR_W-1:0]        IssueReg,
  output logic                     Busy1,
  output logic                     Busy2,
  output logic [(1<<ADDR_W)-1:0]   WriteEn
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [NREG-1:0]   busy_q;
  logic [NREG-1:0]   busy_d;
  logic [NREG-1:0]   issueVec;

  always_comb begin
    WriteEn  = '0;
    issueVec = '0;
    if (RegWrite && !reset) WriteEn[WriteRegister] = 1'b1;
    if (IssueValid && !reset) issueVec[IssueReg] = 1'b1;
    if (ZERO_REG != 0) begin
      WriteEn[0]  = 1'b0;
      issueVec[0] = 1'b0;
    end
  end

  // A fresh issue outranks a completing write: the new producer supersedes it.
  always_comb begin
    busy_d = (busy_q & ~WriteEn) | issueVec;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      busy_q <= busy_d;
      for (int i = 0; i < NREG; i++) begin
        if (WriteEn[i]) regs_q[i] <= WriteData;
      end
    end
  end

  always_comb begin
    ReadData1 = regs_q[ReadReg1];
    Busy1     = busy_q[ReadReg1];
    if ((BYPASS != 0) && WriteEn[ReadReg1]) begin
      ReadData1 = WriteData;
      Busy1     = issueVec[ReadReg1];
    end
    if ((ZERO_REG != 0) && (ReadReg1 == '0)) begin
      ReadData1 = '0;
      Busy1     = 1'b0;
    end
  end

  always_comb begin
    ReadData2 = regs_q[ReadReg2];
    Busy2     = busy_q[ReadReg2];
    if ((BYPASS != 0) && WriteEn[ReadReg2]) begin
      ReadData2 = WriteData;
      Busy2     = issueVec[ReadReg2];
    end
    if ((ZERO_REG != 0) && (ReadReg2 == '0)) begin
      ReadData2 = '0;
      Busy2     = 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_wb.sv
// Bench for regfile_wb: a default instance (A) and a small no-zero, no-bypass
// instance (B) are driven together and compared against an array-based model.
module tb_regfile_wb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        aWe, aIv, aB1, aB2;
  logic [4:0]  aWa, aR1, aR2, aIr;
  logic [31:0] aWd, aRd1, aRd2, aWen;
  logic        bWe, bIv, bB1, bB2;
  logic [2:0]  bWa, bR1, bR2, bIr;
  logic [7:0]  bWd, bRd1, bRd2, bWen;

  int testCount = 0;
  int failCount = 0;

  logic [31:0] memA [32];
  logic        busyA [32];
  logic [7:0]  memB [8];
  logic        busyB [8];

  regfile_wb dutA (
    .clk(clk), .reset(reset), .RegWrite(aWe), .WriteRegister(aWa), .WriteData(aWd),
    .ReadReg1(aR1), .ReadReg2(aR2), .ReadData1(aRd1), .ReadData2(aRd2),
    .IssueValid(aIv), .IssueReg(aIr), .Busy1(aB1), .Busy2(aB2), .WriteEn(aWen)
  );

  regfile_wb #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(0), .BYPASS(0)) dutB (
    .clk(clk), .reset(reset), .RegWrite(bWe), .WriteRegister(bWa), .WriteData(bWd),
    .ReadReg1(bR1), .ReadReg2(bR2), .ReadData1(bRd1), .ReadData2(bRd2),
    .IssueValid(bIv), .IssueReg(bIr), .Busy1(bB1), .Busy2(bB2), .WriteEn(bWen)
  );

  // Expected values follow the written rules: zero register, write-through, pending state.
  function automatic logic [63:0] expWe(int zr, logic rst, logic we, int wa);
    if (rst || !we || (zr != 0 && wa == 0)) return 64'd0;
    return 64'd1 << wa;
  endfunction

  function automatic logic [63:0] expRead(int zr, int bp, logic rst, logic we, int wa,
                                          logic [31:0] wd, int ra, logic [31:0] stored);
    if (zr != 0 && ra == 0) return 64'd0;
    if (bp != 0 && expWe(zr, rst, we, wa) != 0 && wa == ra) return {32'd0, wd};
    return {32'd0, stored};
  endfunction

  function automatic logic [63:0] expBusy(int zr, int bp, logic rst, logic we, int wa,
                                          logic iv, int ir, int ra, logic stored);
    if (zr != 0 && ra == 0) return 64'd0;
    if (bp != 0 && expWe(zr, rst, we, wa) != 0 && wa == ra)
      return {63'd0, (iv && !rst && ir == ra)};
    return {63'd0, stored};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    testCount++;
    assert (got === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic we, input int wa, input logic [31:0] wd,
                               input int r1, input int r2, input logic iv, input int ir);
    reset = rst; aWe = we; aWa = 5'(wa); aWd = wd;
    aR1 = 5'(r1); aR2 = 5'(r2); aIv = iv; aIr = 5'(ir);
  endtask

  task automatic applyStimulusB(input logic we, input int wa, input logic [7:0] wd,
                                input int r1, input int r2, input logic iv, input int ir);
    bWe = we; bWa = 3'(wa); bWd = wd;
    bR1 = 3'(r1); bR2 = 3'(r2); bIv = iv; bIr = 3'(ir);
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".A.WriteEn"}, aWen, expWe(1, reset, aWe, int'(aWa)));
    checkOutput({tag, ".A.Rd1"}, aRd1, expRead(1, 1, reset, aWe, int'(aWa), aWd, int'(aR1), memA[aR1]));
    checkOutput({tag, ".A.Rd2"}, aRd2, expRead(1, 1, reset, aWe, int'(aWa), aWd, int'(aR2), memA[aR2]));
    checkOutput({tag, ".A.Busy1"}, aB1, expBusy(1, 1, reset, aWe, int'(aWa), aIv, int'(aIr), int'(aR1), busyA[aR1]));
    checkOutput({tag, ".A.Busy2"}, aB2, expBusy(1, 1, reset, aWe, int'(aWa), aIv, int'(aIr), int'(aR2), busyA[aR2]));
    checkOutput({tag, ".B.WriteEn"}, bWen, expWe(0, reset, bWe, int'(bWa)));
    checkOutput({tag, ".B.Rd1"}, bRd1, expRead(0, 0, reset, bWe, int'(bWa), 32'(bWd), int'(bR1), 32'(memB[bR1])));
    checkOutput({tag, ".B.Rd2"}, bRd2, expRead(0, 0, reset, bWe, int'(bWa), 32'(bWd), int'(bR2), 32'(memB[bR2])));
    checkOutput({tag, ".B.Busy1"}, bB1, expBusy(0, 0, reset, bWe, int'(bWa), bIv, int'(bIr), int'(bR1), busyB[bR1]));
    checkOutput({tag, ".B.Busy2"}, bB2, expBusy(0, 0, reset, bWe, int'(bWa), bIv, int'(bIr), int'(bR2), busyB[bR2]));
  endtask

  task automatic updateModels();
    if (reset) begin
      for (int i = 0; i < 32; i++) begin memA[i] = '0; busyA[i] = 1'b0; end
      for (int i = 0; i < 8; i++) begin memB[i] = '0; busyB[i] = 1'b0; end
    end else begin
      if (aWe && aWa != 0) begin memA[aWa] = aWd; busyA[aWa] = 1'b0; end
      if (aIv && aIr != 0) busyA[aIr] = 1'b1;
      if (bWe) begin memB[bWa] = bWd; busyB[bWa] = 1'b0; end
      if (bIv) busyB[bIr] = 1'b1;
    end
  endtask

  // Inputs change on the falling edge; outputs are compared 1 time unit later.
  task automatic cycle(input string tag);
    #1;
    checkAll(tag);
    @(posedge clk);
    updateModels();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin memA[i] = 'x; busyA[i] = 1'bx; end
    for (int i = 0; i < 8; i++) begin memB[i] = 'x; busyB[i] = 1'bx; end
    applyStimulus(1'b1, 1'b1, 3, 32'hAAAA5555, 0, 0, 1'b1, 4);
    applyStimulusB(1'b1, 3, 8'h55, 0, 0, 1'b1, 4);
    @(negedge clk);
    @(posedge clk);
    updateModels();
    @(negedge clk);
    #1;
    checkOutput("rst.WriteEnZero", aWen, 64'd0);
    cycle("rst");

    applyStimulus(1'b0, 1'b1, 5, 32'hDEADBEEF, 0, 0, 1'b0, 0);
    applyStimulusB(1'b0, 0, 8'h00, 0, 0, 1'b0, 0);
    #1 checkOutput("wr5.WriteEn", aWen, 64'h20);
    cycle("wr5");
    applyStimulus(1'b0, 1'b0, 0, 32'h0, 5, 5, 1'b0, 0);
    #1 checkOutput("rd5", aRd1, 64'hDEADBEEF);
    cycle("rd5");

    applyStimulus(1'b0, 1'b1, 0, 32'hFFFFFFFF, 0, 0, 1'b1, 0);
    #1 checkOutput("zero.WriteEn", aWen, 64'd0);
    checkOutput("zero.Rd1", aRd1, 64'd0);
    cycle("zero");
    applyStimulus(1'b0, 1'b0, 0, 32'h0, 0, 0, 1'b0, 0);
    #1 checkOutput("zero.Busy1", aB1, 64'd0);
    cycle("zero2");

    applyStimulus(1'b0, 1'b1, 7, 32'h12345678, 0, 7, 1'b0, 0);
    applyStimulusB(1'b1, 7, 8'h78, 0, 7, 1'b0, 0);
    #1 checkOutput("bypass.A", aRd2, 64'h12345678);
    checkOutput("bypass.Bold", bRd2, 64'h0);
    cycle("bypass");
    applyStimulusB(1'b0, 0, 8'h00, 0, 7, 1'b0, 0);
    #1 checkOutput("bypass.Bnew", bRd2, 64'h78);
    cycle("bypass2");

    applyStimulus(1'b0, 1'b0, 0, 32'h0, 9, 0, 1'b1, 9);
    cycle("issue9");
    applyStimulus(1'b0, 1'b0, 0, 32'h0, 9, 0, 1'b0, 0);
    #1 checkOutput("busy9.set", aB1, 64'd1);
    cycle("busy9");
    applyStimulus(1'b0, 1'b1, 9, 32'h99, 0, 0, 1'b0, 0);
    cycle("wr9");
    applyStimulus(1'b0, 1'b1, 9, 32'h98, 9, 0, 1'b1, 9);
    #1 checkOutput("busy9.clr", aB1, 64'd1);
    cycle("both9");
    applyStimulus(1'b0, 1'b0, 0, 32'h0, 9, 0, 1'b0, 0);
    #1 checkOutput("busy9.win", aB1, 64'd1);
    cycle("busy9b");

    applyStimulus(1'b0, 1'b1, 3, 32'h33, 0, 0, 1'b0, 0);
    cycle("wr3");
    applyStimulus(1'b0, 1'b1, 4, 32'h44, 0, 0, 1'b0, 0);
    cycle("wr4");
    applyStimulus(1'b0, 1'b0, 0, 32'h0, 0, 0, 1'b1, 4);
    cycle("iss4");
    applyStimulus(1'b1, 1'b1, 3, 32'h3333, 3, 4, 1'b1, 4);
    #1 checkOutput("midrst.WriteEn", aWen, 64'd0);
    cycle("midrst");
    applyStimulus(1'b0, 1'b0, 0, 32'h0, 3, 4, 1'b0, 0);
    #1 checkOutput("midrst.Rd3", aRd1, 64'd0);
    checkOutput("midrst.Rd4", aRd2, 64'd0);
    checkOutput("midrst.Busy4", aB2, 64'd0);
    cycle("postrst");

    for (int a = 0; a < 8; a++) begin
      applyStimulusB(1'b1, a, 8'(8'hA0 + a), a, 0, 1'b1, 0);
      #1 checkOutput("sweep.WriteEn", bWen, 64'd1 << a);
      cycle("sweep");
    end
    applyStimulusB(1'b0, 0, 8'h00, 0, 0, 1'b0, 0);
    #1 checkOutput("sweep.Busy0", bB1, 64'd1);
    checkOutput("sweep.Rd0", bRd1, 64'hA0);
    cycle("sweep2");

    for (int n = 0; n < 400; n++) begin
      logic rst;
      int span;
      rst = ($urandom_range(0, 49) == 0);
      span = ($urandom_range(0, 1) == 0) ? 7 : 31;
      applyStimulus(rst, 1'($urandom_range(0, 1)), int'($urandom_range(0, span)), $urandom,
                    int'($urandom_range(0, span)), int'($urandom_range(0, span)),
                    1'($urandom_range(0, 1)), int'($urandom_range(0, span)));
      applyStimulusB(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), 8'($urandom),
                     int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                     1'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
      cycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
